// File: rtl/uart_pkg.sv
// Shared types and helpers for the uart_txrx core.
// The PARITY states exist only when UART_PARITY_EN is defined.
package uart_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
`ifdef UART_PARITY_EN
        TX_PARITY,
`endif
        TX_STOP
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_DATA,
`ifdef UART_PARITY_EN
        RX_PARITY,
`endif
        RX_STOP
    } rx_state_t;

    // Clock cycles per bit period (integer division).
    function automatic int calc_div(input int clk_freq, input int baud_rate);
        return clk_freq / baud_rate;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Baud-rate clock-enable generator: a 0..DIV-1 wrapping counter and a
// registered one-clock tick issued when the counter reaches DIV-1.
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = 10000,
    parameter int BAUD_RATE = 1000
) (
    input  logic clk,
    input  logic rst,
    output logic baud_tick
);

    localparam int DIV   = calc_div(CLK_FREQ, BAUD_RATE);
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

    generate
        if (DIV < 2) begin : g_div_check
            $error("uart_baud_gen: CLK_FREQ/BAUD_RATE must be at least 2");
        end
    endgenerate

    logic [CNT_W-1:0] cnt_q;

    // Free-running divider; the tick is registered so it is glitch-free.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            baud_tick <= 1'b0;
        end else begin
            cnt_q     <= (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
            baud_tick <= (cnt_q == CNT_LAST);
        end
    end

endmodule

// File: rtl/uart_txrx.sv
// Full-duplex UART (8N1 by default, 8E1 when UART_PARITY_EN is defined).
// TX and RX share one baud tick; RX samples once per tick (no oversampling).
module uart_txrx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 10000,
    parameter int BAUD_RATE  = 1000,
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  data_ready,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  tx_serial,
    output logic                  tx_busy,
    input  logic                  rx_serial,
    output logic                  data_valid,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  frame_err,
    output logic                  parity_err,
    output logic                  baud_tick
);

    localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_WIDTH - 1);

    uart_baud_gen #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD_RATE(BAUD_RATE)
    ) u_baud_gen (
        .clk      (clk),
        .rst      (rst),
        .baud_tick(baud_tick)
    );

    // ---------------- transmitter ----------------
    tx_state_t             tx_state_q, tx_state_d;
    logic                  tx_busy_q, tx_busy_d;
    logic                  tx_bit_q, tx_bit_d;
    logic [IDX_W-1:0]      tx_idx_q, tx_idx_d;
    logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
    logic [IDX_W-1:0]      tx_idx_nxt;

    assign tx_idx_nxt = tx_idx_q + 1'b1;

    // TX next state: the state names the bit currently on the line.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_busy_d  = tx_busy_q;
        tx_bit_d   = tx_bit_q;
        tx_idx_d   = tx_idx_q;
        tx_data_d  = tx_data_q;
        if (baud_tick) begin
            unique case (tx_state_q)
                TX_IDLE: begin
                    if (tx_busy_q) begin
                        tx_state_d = TX_START;
                        tx_bit_d   = 1'b0;
                    end
                end
                TX_START: begin
                    tx_state_d = TX_DATA;
                    tx_idx_d   = '0;
                    tx_bit_d   = tx_data_q[0];
                end
                TX_DATA: begin
                    if (tx_idx_q == IDX_LAST) begin
`ifdef UART_PARITY_EN
                        tx_state_d = TX_PARITY;
                        tx_bit_d   = ^tx_data_q;
`else
                        tx_state_d = TX_STOP;
                        tx_bit_d   = 1'b1;
`endif
                    end else begin
                        tx_idx_d = tx_idx_nxt;
                        tx_bit_d = tx_data_q[tx_idx_nxt];
                    end
                end
`ifdef UART_PARITY_EN
                TX_PARITY: begin
                    tx_state_d = TX_STOP;
                    tx_bit_d   = 1'b1;
                end
`endif
                TX_STOP: begin
                    tx_state_d = TX_IDLE;
                    tx_busy_d  = 1'b0;
                end
                default: begin
                    tx_state_d = TX_IDLE;
                    tx_busy_d  = 1'b0;
                    tx_bit_d   = 1'b1;
                end
            endcase
        end
        // A load is taken when idle, or on the very tick that ends STOP.
        if (data_ready && (!tx_busy_q || (tx_state_q == TX_STOP && baud_tick))) begin
            tx_data_d = data_in;
            tx_busy_d = 1'b1;
        end
    end

    // TX control registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state_q <= TX_IDLE;
            tx_busy_q  <= 1'b0;
            tx_bit_q   <= 1'b1;
            tx_idx_q   <= '0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_busy_q  <= tx_busy_d;
            tx_bit_q   <= tx_bit_d;
            tx_idx_q   <= tx_idx_d;
        end
    end

    // TX holding register; only meaningful while busy, so not reset.
    always_ff @(posedge clk) tx_data_q <= tx_data_d;

    assign tx_serial = tx_bit_q;
    assign tx_busy   = tx_busy_q;

    // ---------------- receiver ----------------
    rx_state_t             rx_state_q, rx_state_d;
    logic [IDX_W-1:0]      rx_idx_q, rx_idx_d;
    logic [DATA_WIDTH-1:0] rx_shreg_q, rx_shreg_d;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic                  data_valid_q, data_valid_d;
    logic                  frame_err_q, frame_err_d;
`ifdef UART_PARITY_EN
    logic                  parity_err_q, parity_err_d;
`endif

    // RX next state: one sample per tick, pulses default low.
    always_comb begin
        rx_state_d   = rx_state_q;
        rx_idx_d     = rx_idx_q;
        rx_shreg_d   = rx_shreg_q;
        data_out_d   = data_out_q;
        data_valid_d = 1'b0;
        frame_err_d  = 1'b0;
`ifdef UART_PARITY_EN
        parity_err_d = 1'b0;
`endif
        if (baud_tick) begin
            unique case (rx_state_q)
                RX_IDLE: begin
                    if (!rx_serial) begin
                        rx_state_d = RX_DATA;
                        rx_idx_d   = '0;
                    end
                end
                RX_DATA: begin
                    rx_shreg_d                 = rx_shreg_q >> 1;
                    rx_shreg_d[DATA_WIDTH-1]   = rx_serial;
                    if (rx_idx_q == IDX_LAST) begin
`ifdef UART_PARITY_EN
                        rx_state_d = RX_PARITY;
`else
                        rx_state_d = RX_STOP;
`endif
                    end else begin
                        rx_idx_d = rx_idx_q + 1'b1;
                    end
                end
`ifdef UART_PARITY_EN
                RX_PARITY: begin
                    parity_err_d = (rx_serial != ^rx_shreg_q);
                    rx_state_d   = RX_STOP;
                end
`endif
                RX_STOP: begin
                    if (rx_serial) begin
                        data_out_d   = rx_shreg_q;
                        data_valid_d = 1'b1;
                    end else begin
                        frame_err_d  = 1'b1;
                    end
                    rx_state_d = RX_IDLE;
                end
                default: rx_state_d = RX_IDLE;
            endcase
        end
    end

    // RX control and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state_q   <= RX_IDLE;
            rx_idx_q     <= '0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
`ifdef UART_PARITY_EN
            parity_err_q <= 1'b0;
`endif
        end else begin
            rx_state_q   <= rx_state_d;
            rx_idx_q     <= rx_idx_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            frame_err_q  <= frame_err_d;
`ifdef UART_PARITY_EN
            parity_err_q <= parity_err_d;
`endif
        end
    end

    // RX shift register; contents are only used once a frame completes.
    always_ff @(posedge clk) rx_shreg_q <= rx_shreg_d;

    assign data_valid = data_valid_q;
    assign data_out   = data_out_q;
    assign frame_err  = frame_err_q;
`ifdef UART_PARITY_EN
    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_txrx.sv
// Self-checking bench for uart_txrx: loopback traffic, direct RX frames with
// stop/parity faults, and a mid-frame reset. Follows UART_PARITY_EN.
module tb_uart_txrx;

    localparam int CLK_FREQ  = 10000;
    localparam int BAUD_RATE = 1000;
    localparam int DIV       = CLK_FREQ / BAUD_RATE;
`ifdef UART_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif
    localparam int FRAME_BITS = PAR_EN ? 11 : 10;

    logic       clk = 1'b0;
    logic       rst;
    logic       data_ready;
    logic [7:0] data_in;
    logic       tx_serial;
    logic       tx_busy;
    logic       rx_line;
    logic       data_valid;
    logic [7:0] data_out;
    logic       frame_err;
    logic       parity_err;
    logic       baud_tick;
    logic       loopback;
    logic       rx_drv;

    int checks   = 0;
    int failures = 0;
    int dv_count = 0;
    int fe_count = 0;
    int pe_count = 0;
    logic [7:0]  exp_last;
    logic [31:0] last_seen;

    assign rx_line = loopback ? tx_serial : rx_drv;

    uart_txrx #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUD_RATE (BAUD_RATE),
        .DATA_WIDTH(8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .data_ready(data_ready),
        .data_in   (data_in),
        .tx_serial (tx_serial),
        .tx_busy   (tx_busy),
        .rx_serial (rx_line),
        .data_valid(data_valid),
        .data_out  (data_out),
        .frame_err (frame_err),
        .parity_err(parity_err),
        .baud_tick (baud_tick)
    );

    always #5 clk = ~clk;

    // Pulse counters, sampled away from the active edge.
    always @(negedge clk) begin
        if (data_valid) dv_count <= dv_count + 1;
        if (frame_err)  fe_count <= fe_count + 1;
        if (parity_err) pe_count <= pe_count + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Reference frame: start 0, data LSB first, optional even parity, stop.
    function automatic logic [31:0] mk_frame(input logic [7:0] d, input logic par, input logic stop);
        logic [31:0] f;
        f = '0;
        for (int i = 0; i < 8; i++) f[i+1] = d[i];
        if (PAR_EN) f[9] = par;
        f[FRAME_BITS-1] = stop;
        return f;
    endfunction

    // Returns at a negedge where baud_tick is high (next posedge is a tick edge).
    task automatic wait_tick(input string tag, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 3 * DIV; i++) begin
            if (baud_tick) begin
                ok = 1'b1;
                return;
            end
            @(negedge clk);
        end
        chk({tag, "_tick_timeout"}, {31'd0, baud_tick}, 32'd1);
    endtask

    task automatic send_and_check(input logic [7:0] b, input string tag);
        int          cyc;
        bit          ok;
        bit          got;
        int          fe0;
        int          pe0;
        logic [31:0] seen;
        fe0 = fe_count;
        pe0 = pe_count;
        data_in    = b;
        data_ready = 1'b1;
        @(negedge clk);
        data_ready = 1'b0;
        chk({tag, "_busy_set"}, {31'd0, tx_busy}, 32'd1);
        wait_tick(tag, ok);
        if (!ok) return;
        @(negedge clk);
        seen    = '0;
        seen[0] = tx_serial;
        cyc     = 0;
        got     = 1'b0;
        while (cyc < (FRAME_BITS + 5) * DIV) begin
            @(negedge clk);
            cyc++;
            if ((cyc % DIV) == 0 && (cyc / DIV) < FRAME_BITS) seen[cyc/DIV] = tx_serial;
            if (data_valid) begin
                got = 1'b1;
                break;
            end
        end
        last_seen = seen;
        chk({tag, "_latency"}, got ? cyc : -1, FRAME_BITS * DIV);
        chk({tag, "_tx_frame"}, seen, mk_frame(b, ^b, 1'b1));
        chk({tag, "_data_out"}, {24'd0, data_out}, {24'd0, b});
        chk({tag, "_busy_clr"}, {31'd0, tx_busy}, 32'd0);
        @(negedge clk);
        chk({tag, "_no_err"}, (fe_count - fe0) + (pe_count - pe0), 0);
        exp_last = b;
    endtask

    // Drives a frame on rx_drv, bit j held from just after tick j.
    task automatic drive_frame(input logic [31:0] bits, input string tag);
        bit ok;
        for (int j = 0; j < FRAME_BITS; j++) begin
            wait_tick(tag, ok);
            if (!ok) return;
            @(negedge clk);
            rx_drv = bits[j];
        end
        wait_tick(tag, ok);
        @(negedge clk);
        @(negedge clk);
        rx_drv = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          dv0;
        int          fe0;
        int          pe0;
        int          cyc;
        bit          ok;
        logic [7:0]  r;
        logic [7:0]  fixed_bytes [5];

        fixed_bytes = '{8'h43, 8'h72, 8'hA5, 8'hE7, 8'hF4};
        rst        = 1'b1;
        data_ready = 1'b0;
        data_in    = '0;
        loopback   = 1'b1;
        rx_drv     = 1'b1;
        exp_last   = '0;
        last_seen  = '0;

        // Reset state
        repeat (5) @(negedge clk);
        chk("rst_tx_serial",  {31'd0, tx_serial},  32'd1);
        chk("rst_tx_busy",    {31'd0, tx_busy},    32'd0);
        chk("rst_data_valid", {31'd0, data_valid}, 32'd0);
        chk("rst_frame_err",  {31'd0, frame_err},  32'd0);
        chk("rst_parity_err", {31'd0, parity_err}, 32'd0);
        chk("rst_baud_tick",  {31'd0, baud_tick},  32'd0);
        chk("rst_data_out",   {24'd0, data_out},   32'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Loopback with the listed bytes, then a few random ones
        for (int i = 0; i < 5; i++) begin
            send_and_check(fixed_bytes[i], $sformatf("lb%0d", i));
            if (fixed_bytes[i] == 8'hA5)
                chk("a5_line", last_seen, PAR_EN ? 32'b1_0_10100101_0 : 32'b1_10100101_0);
        end
        for (int i = 0; i < 3; i++) begin
            r = 8'($urandom_range(0, 255));
            send_and_check(r, $sformatf("rnd%0d", i));
        end

        // Load held across STOP is taken on the tick ending STOP
        data_in    = 8'h3C;
        data_ready = 1'b1;
        @(negedge clk);
        data_in = 8'hC3;
        cyc = 0;
        while (!data_valid && cyc < 3 * FRAME_BITS * DIV) begin
            @(negedge clk);
            cyc++;
        end
        data_ready = 1'b0;
        chk("b2b_first", {24'd0, data_out}, 32'h3C);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!data_valid && cyc < 3 * FRAME_BITS * DIV);
        chk("b2b_gap", cyc, (FRAME_BITS + 1) * DIV);
        chk("b2b_second", {24'd0, data_out}, 32'hC3);
        exp_last = 8'hC3;
        repeat (2 * DIV) @(negedge clk);

        // Direct RX: stop bit low
        loopback = 1'b0;
        r   = 8'($urandom_range(0, 255));
        dv0 = dv_count;
        fe0 = fe_count;
        pe0 = pe_count;
        drive_frame(mk_frame(r, ^r, 1'b0), "ferr");
        chk("ferr_pulse",    fe_count - fe0, 1);
        chk("ferr_no_valid", dv_count - dv0, 0);
        chk("ferr_no_perr",  pe_count - pe0, 0);
        chk("ferr_data_out", {24'd0, data_out}, {24'd0, exp_last});

        // Direct RX: 0x43 with the parity bit flipped
        dv0 = dv_count;
        fe0 = fe_count;
        pe0 = pe_count;
        drive_frame(mk_frame(8'h43, ~^8'h43, 1'b1), "perr");
        chk("perr_pulse",    pe_count - pe0, PAR_EN ? 1 : 0);
        chk("perr_valid",    dv_count - dv0, 1);
        chk("perr_no_ferr",  fe_count - fe0, 0);
        chk("perr_data_out", {24'd0, data_out}, 32'h43);
        exp_last = 8'h43;
        loopback = 1'b1;
        repeat (2 * DIV) @(negedge clk);

        // Reset during the data bits of 0xE7
        dv0        = dv_count;
        data_in    = 8'hE7;
        data_ready = 1'b1;
        @(negedge clk);
        data_ready = 1'b0;
        wait_tick("rstmid", ok);
        @(negedge clk);
        repeat (3 * DIV) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rstmid_tx_serial", {31'd0, tx_serial}, 32'd1);
        chk("rstmid_tx_busy",   {31'd0, tx_busy},   32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat ((FRAME_BITS + 2) * DIV) @(negedge clk);
        chk("rstmid_no_valid", dv_count - dv0, 0);
        chk("rstmid_data_out", {24'd0, data_out}, 32'd0);
        exp_last = 8'h00;
        send_and_check(8'hF4, "after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
